// File: rtl/fsm_obs_pkg.sv
// Shared types for the fsm_obs observer: state codes, output-vector bit positions,
// and the decode-result record produced by the table lookup.
package fsm_obs_pkg;

  typedef enum logic [3:0] {
    Z0 = 4'd0, Z1 = 4'd1, Z2 = 4'd2, Z3 = 4'd3, Z4 = 4'd4,
    Z5 = 4'd5, Z6 = 4'd6, Z7 = 4'd7, Z8 = 4'd8
  } state_e;

  localparam int unsigned NSTATE = 9;

  localparam int unsigned T1 = 0;
  localparam int unsigned T2 = 1;
  localparam int unsigned T3 = 2;
  localparam int unsigned T4 = 3;
  localparam int unsigned T9 = 4;

  typedef struct packed {
    logic   legal;
    logic   x;
    logic   x_ok;
    logic   y;
    logic   y_ok;
    state_e nxt;
  } dec_t;

  // Legal entry that determines x only (every state except Z2).
  function automatic dec_t dec_x(input logic x, input state_e nxt);
    dec_t d;
    d.legal = 1'b1;
    d.x     = x;
    d.x_ok  = 1'b1;
    d.y     = 1'b0;
    d.y_ok  = 1'b0;
    d.nxt   = nxt;
    return d;
  endfunction

endpackage

// File: rtl/fsm_obs_dec.sv
// Combinational transition-table lookup: (tracked state, output vector) -> decode result.
// tvec bit order is {t9,t4,t3,t2,t1}.
module fsm_obs_dec
  import fsm_obs_pkg::*;
(
  input  logic [3:0] st,
  input  logic [4:0] tvec,
  output dec_t       dec
);

  always_comb begin
    dec       = '0;
    dec.nxt   = Z0;
    unique case (st)
      Z0: unique case (tvec)
            5'b00000: dec = dec_x(1'b0, Z0);
            5'b00010: dec = dec_x(1'b1, Z4);
            default:  ;
          endcase
      Z1: unique case (tvec)
            5'b00000: dec = dec_x(1'b0, Z0);
            5'b10000: dec = dec_x(1'b1, Z5);
            default:  ;
          endcase
      Z2: begin
            // Only Z2 branches on y; its y1 exit does not depend on x.
            dec.y_ok = 1'b1;
            unique case (tvec)
              5'b00000: begin dec.legal = 1'b1; dec.x = 1'b1; dec.x_ok = 1'b1; dec.nxt = Z1; end
              5'b00010: begin dec.legal = 1'b1; dec.x = 1'b0; dec.x_ok = 1'b1; dec.nxt = Z7; end
              5'b01111: begin dec.legal = 1'b1; dec.y = 1'b1; dec.nxt = Z7; end
              default:  dec.y_ok = 1'b0;
            endcase
          end
      Z3: unique case (tvec)
            5'b10000: dec = dec_x(1'b0, Z0);
            5'b00000: dec = dec_x(1'b1, Z0);
            default:  ;
          endcase
      Z4: unique case (tvec)
            5'b00000: dec = dec_x(1'b0, Z0);
            5'b01000: dec = dec_x(1'b1, Z3);
            default:  ;
          endcase
      Z5: unique case (tvec)
            5'b00011: dec = dec_x(1'b0, Z8);
            5'b00001: dec = dec_x(1'b1, Z6);
            default:  ;
          endcase
      Z6: unique case (tvec)
            5'b00000: dec = dec_x(1'b0, Z5);
            5'b00010: dec = dec_x(1'b1, Z7);
            default:  ;
          endcase
      Z7: unique case (tvec)
            5'b00001: dec = dec_x(1'b0, Z6);
            5'b00011: dec = dec_x(1'b1, Z8);
            default:  ;
          endcase
      Z8: unique case (tvec)
            5'b00010: dec = dec_x(1'b0, Z7);
            5'b00000: dec = dec_x(1'b1, Z5);
            default:  ;
          endcase
      default: ;
    endcase
  end

endmodule

// File: rtl/fsm_obs.sv
// Output-side observer for the 9-state Mealy control automaton: tracks state,
// reconstructs x/y, flags and counts illegal samples. Optional cross-check: FSM_OBS_XCHK_EN.
module fsm_obs
  import fsm_obs_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             smp,
  input  logic             t1,
  input  logic             t2,
  input  logic             t3,
  input  logic             t4,
  input  logic             t9,
  input  logic             ld,
  input  logic [3:0]       ld_st,
`ifdef FSM_OBS_XCHK_EN
  input  logic             x_ref,
  input  logic             y_ref,
`endif
  output logic [3:0]       st,
  output logic             x_rec,
  output logic             x_ok,
  output logic             y_rec,
  output logic             y_ok,
  output logic             err,
  output logic             lock,
`ifdef FSM_OBS_XCHK_EN
  output logic             mis,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned RUN_W = $clog2(LOCK_LEN + 1);

  logic [4:0] tvec;
  dec_t       dec;

  state_e           st_q, st_d;
  logic             x_rec_q, x_rec_d, x_ok_q, x_ok_d;
  logic             y_rec_q, y_rec_d, y_ok_q, y_ok_d;
  logic             err_q, err_d, lock_q, lock_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, err_cnt_inc;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
`ifdef FSM_OBS_XCHK_EN
  logic             mis_q, mis_d;
`endif

  always_comb begin
    tvec     = '0;
    tvec[T1] = t1;
    tvec[T2] = t2;
    tvec[T3] = t3;
    tvec[T4] = t4;
    tvec[T9] = t9;
  end

  fsm_obs_dec u_dec (
    .st   (st_q),
    .tvec (tvec),
    .dec  (dec)
  );

  assign err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
  assign run_inc     = run_q + RUN_W'(1);

  always_comb begin
    st_d      = st_q;
    x_rec_d   = x_rec_q;
    x_ok_d    = x_ok_q;
    y_rec_d   = y_rec_q;
    y_ok_d    = y_ok_q;
    err_d     = 1'b0;
    lock_d    = lock_q;
    err_cnt_d = err_cnt_q;
    run_d     = run_q;
`ifdef FSM_OBS_XCHK_EN
    mis_d     = 1'b0;
`endif
    if (ld) begin
      if (ld_st <= 4'(NSTATE - 1)) begin
        st_d   = state_e'(ld_st);
        lock_d = 1'b1;
        run_d  = '0;
        x_ok_d = 1'b0;
        y_ok_d = 1'b0;
      end else begin
        err_d     = 1'b1;
        err_cnt_d = err_cnt_inc;
      end
    end else if (smp) begin
      if (dec.legal) begin
        st_d    = dec.nxt;
        x_rec_d = dec.x;
        x_ok_d  = dec.x_ok;
        y_rec_d = dec.y;
        y_ok_d  = dec.y_ok;
        // While out of lock, count consecutive legal samples toward re-lock.
        if (!lock_q) begin
          if (run_inc == RUN_W'(LOCK_LEN)) begin
            lock_d = 1'b1;
            run_d  = '0;
          end else begin
            run_d = run_inc;
          end
        end
`ifdef FSM_OBS_XCHK_EN
        mis_d = (dec.x_ok & (dec.x != x_ref)) | (dec.y_ok & (dec.y != y_ref));
`endif
      end else begin
        st_d      = Z0;
        lock_d    = 1'b0;
        run_d     = '0;
        x_ok_d    = 1'b0;
        y_ok_d    = 1'b0;
        err_d     = 1'b1;
        err_cnt_d = err_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      st_q      <= Z0;
      x_rec_q   <= 1'b0;
      x_ok_q    <= 1'b0;
      y_rec_q   <= 1'b0;
      y_ok_q    <= 1'b0;
      err_q     <= 1'b0;
      lock_q    <= 1'b1;
      err_cnt_q <= '0;
      run_q     <= '0;
`ifdef FSM_OBS_XCHK_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      st_q      <= st_d;
      x_rec_q   <= x_rec_d;
      x_ok_q    <= x_ok_d;
      y_rec_q   <= y_rec_d;
      y_ok_q    <= y_ok_d;
      err_q     <= err_d;
      lock_q    <= lock_d;
      err_cnt_q <= err_cnt_d;
      run_q     <= run_d;
`ifdef FSM_OBS_XCHK_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign st      = st_q;
  assign x_rec   = x_rec_q;
  assign x_ok    = x_ok_q;
  assign y_rec   = y_rec_q;
  assign y_ok    = y_ok_q;
  assign err     = err_q;
  assign lock    = lock_q;
  assign err_cnt = err_cnt_q;
`ifdef FSM_OBS_XCHK_EN
  assign mis     = mis_q;
`endif

endmodule

// File: tb/tb_fsm_obs.sv
// Directed self-checking bench for fsm_obs (default CNT_W=8, LOCK_LEN=4).
module tb_fsm_obs;

  logic       clk = 1'b0;
  logic       res = 1'b0, smp = 1'b0, ld = 1'b0;
  logic       t1 = 1'b0, t2 = 1'b0, t3 = 1'b0, t4 = 1'b0, t9 = 1'b0;
  logic [3:0] ld_st = 4'd0;
  logic [3:0] st;
  logic       x_rec, x_ok, y_rec, y_ok, err, lock;
  logic [7:0] err_cnt;
`ifdef FSM_OBS_XCHK_EN
  logic       x_ref = 1'b0, y_ref = 1'b0, mis;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fsm_obs #(.CNT_W(8), .LOCK_LEN(4)) dut (
    .clk(clk), .res(res), .smp(smp),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t9(t9),
    .ld(ld), .ld_st(ld_st),
`ifdef FSM_OBS_XCHK_EN
    .x_ref(x_ref), .y_ref(y_ref), .mis(mis),
`endif
    .st(st), .x_rec(x_rec), .x_ok(x_ok), .y_rec(y_rec), .y_ok(y_ok),
    .err(err), .lock(lock), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // v = {t9,t4,t3,t2,t1}
  task automatic tv(input logic [4:0] v);
    {t9, t4, t3, t2, t1} = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    res = 1'b1; smp = 1'b1; ld = 1'b1; ld_st = 4'd5; tv(5'b10000);
    step();
    chk("rst_st", 32'(st), 0);
    chk("rst_lock", 32'(lock), 1);
    chk("rst_cnt", 32'(err_cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_xok", 32'(x_ok), 0);
    chk("rst_yok", 32'(y_ok), 0);
    chk("rst_xrec", 32'(x_rec), 0);
    res = 1'b0; ld = 1'b0;

    // Z0 -{t2}-> Z4 -{t4}-> Z3 -{}-> Z0, all x=1
    tv(5'b00010); step();
    chk("z0_t2_st", 32'(st), 4); chk("z0_t2_x", 32'(x_rec), 1);
    chk("z0_t2_xok", 32'(x_ok), 1); chk("z0_t2_err", 32'(err), 0);
    chk("z0_t2_yok", 32'(y_ok), 0);
    tv(5'b01000); step();
    chk("z4_t4_st", 32'(st), 3); chk("z4_t4_x", 32'(x_rec), 1);
    tv(5'b00000); step();
    chk("z3_n_st", 32'(st), 0); chk("z3_n_x", 32'(x_rec), 1);
    chk("z3_n_lock", 32'(lock), 1);

    // Illegal {t9} in Z0
    tv(5'b10000); step();
    chk("ill_err", 32'(err), 1); chk("ill_cnt", 32'(err_cnt), 1);
    chk("ill_st", 32'(st), 0); chk("ill_lock", 32'(lock), 0);
    chk("ill_xok", 32'(x_ok), 0);
    tv(5'b00000);
    for (int i = 0; i < 3; i++) step();
    chk("run3_lock", 32'(lock), 0); chk("run3_err", 32'(err), 0);
    tv(5'b10000); step();
    chk("ill2_cnt", 32'(err_cnt), 2); chk("ill2_lock", 32'(lock), 0);
    tv(5'b00000);
    for (int i = 0; i < 3; i++) step();
    chk("rerun3_lock", 32'(lock), 0);
    step();
    chk("rerun4_lock", 32'(lock), 1); chk("rerun4_x", 32'(x_rec), 0);
    chk("rerun4_xok", 32'(x_ok), 1);

    // smp=0 holds everything, err pulse stays low
    smp = 1'b0; tv(5'b11111); step();
    chk("hold_st", 32'(st), 0); chk("hold_xok", 32'(x_ok), 1);
    chk("hold_cnt", 32'(err_cnt), 2); chk("hold_err", 32'(err), 0);

    // Preload Z5 (ld beats smp), then Z5->Z8->Z7->Z6->Z5 with x=0
    smp = 1'b1; ld = 1'b1; ld_st = 4'd5; tv(5'b10000); step();
    chk("ld5_st", 32'(st), 5); chk("ld5_xok", 32'(x_ok), 0);
    chk("ld5_err", 32'(err), 0);
    ld = 1'b0;
    tv(5'b00011); step(); chk("z5_st", 32'(st), 8); chk("z5_x", 32'(x_rec), 0);
    tv(5'b00010); step(); chk("z8_st", 32'(st), 7); chk("z8_x", 32'(x_rec), 0);
    tv(5'b00001); step(); chk("z7_st", 32'(st), 6); chk("z7_x", 32'(x_rec), 0);
    tv(5'b00000); step(); chk("z6_st", 32'(st), 5); chk("z6_x", 32'(x_rec), 0);
    chk("z6_xok", 32'(x_ok), 1);

    // Z2 y1 branch, then Z2 x1 y0 branch, then Z1 {t9}
    ld = 1'b1; ld_st = 4'd2; step(); ld = 1'b0;
    tv(5'b01111); step();
    chk("z2y_st", 32'(st), 7); chk("z2y_y", 32'(y_rec), 1);
    chk("z2y_yok", 32'(y_ok), 1); chk("z2y_xok", 32'(x_ok), 0);
    ld = 1'b1; ld_st = 4'd2; step(); ld = 1'b0;
    chk("ld2_yok", 32'(y_ok), 0);
    tv(5'b00000); step();
    chk("z2x_st", 32'(st), 1); chk("z2x_x", 32'(x_rec), 1);
    chk("z2x_xok", 32'(x_ok), 1); chk("z2x_y", 32'(y_rec), 0);
    chk("z2x_yok", 32'(y_ok), 1);
    tv(5'b10000); step();
    chk("z1_st", 32'(st), 5); chk("z1_x", 32'(x_rec), 1);
    chk("z1_yok", 32'(y_ok), 0);

    // Bad preload: err, count, state unchanged
    ld = 1'b1; ld_st = 4'd12; step(); ld = 1'b0;
    chk("bad_ld_err", 32'(err), 1); chk("bad_ld_st", 32'(st), 5);
    chk("bad_ld_cnt", 32'(err_cnt), 3); chk("bad_ld_lock", 32'(lock), 1);

    // Counter saturation: 3 + 256 illegal samples clamps at 255
    tv(5'b10000);
    for (int i = 0; i < 256; i++) step();
    chk("sat_cnt", 32'(err_cnt), 255); chk("sat_err", 32'(err), 1);
    step();
    chk("sat_hold", 32'(err_cnt), 255);

    // Reset mid-sequence overrides ld
    ld = 1'b1; ld_st = 4'd6; step();
    chk("ld6_st", 32'(st), 6);
    res = 1'b1; ld_st = 4'd3; step();
    res = 1'b0; ld = 1'b0;
    chk("mid_rst_st", 32'(st), 0); chk("mid_rst_cnt", 32'(err_cnt), 0);
    chk("mid_rst_lock", 32'(lock), 1); chk("mid_rst_err", 32'(err), 0);

`ifdef FSM_OBS_XCHK_EN
    // Z0 {t2} means x=1; a reference of 0 must mismatch, a correct one must not
    x_ref = 1'b0; tv(5'b00010); step();
    chk("mis_set", 32'(mis), 1);
    x_ref = 1'b0; tv(5'b00000); step();
    chk("mis_clr", 32'(mis), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_obs.md
Name: fsm_obs

Overview:
- Observer/decoder on the output side of the team's 9-state Mealy control automaton (states Z0..Z8; inputs x, y; outputs t1, t2, t3, t4, t9).
- Samples the automaton's output vector every clock and shadow-tracks its state.
- Reconstructs the inputs x and y that produced each sample.
- Flags output combinations the automaton cannot produce, and counts them.

Parameters:
CNT_W, 8, width of the saturating error counter
LOCK_LEN, 4, consecutive legal samples needed to re-assert lock after an error

Ports:
clk  in  1  clock; all state updates on the rising edge
res  in  1  synchronous active-high reset
smp  in  1  sample valid; when 0, all registers hold
t1   in  1  automaton output t1
t2   in  1  automaton output t2
t3   in  1  automaton output t3
t4   in  1  automaton output t4
t9   in  1  automaton output t9
ld   in  1  state preload strobe
ld_st  in  4  preload state index
st   out  4  tracked state, 0..8
x_rec  out  1  reconstructed x
x_ok  out  1  x_rec is determined
y_rec  out  1  reconstructed y
y_ok  out  1  y_rec is determined
err  out  1  one-cycle pulse: illegal sample or bad preload
lock  out  1  observer in sync
err_cnt  out  CNT_W  saturating count of errors

Behaviour:
- Reset: res=1 at a rising edge forces:
  - st=0, lock=1, err_cnt=0;
  - err, x_rec, x_ok, y_rec, y_ok all 0.
  - res has priority over ld and smp.
- Priority order: res, then ld, then smp.
- ld=1:
  - If ld_st<=8: st<=ld_st, lock<=1, err<=0, x_ok<=0, y_ok<=0.
  - If ld_st>8: st unchanged, err<=1, err_cnt increments.
- Each smp=1 edge looks up (st, {t9,t4,t3,t2,t1}) in the table below. Listed sets are the asserted outputs; every other output must be 0.
  - Z0: {} -> x0, Z0; {t2} -> x1, Z4
  - Z1: {} -> x0, Z0; {t9} -> x1, Z5
  - Z2: {} -> x1 y0, Z1; {t2} -> x0 y0, Z7; {t1,t2,t3,t4} -> y1 (x unknown), Z7
  - Z3: {t9} -> x0, Z0; {} -> x1, Z0
  - Z4: {} -> x0, Z0; {t4} -> x1, Z3
  - Z5: {t1,t2} -> x0, Z8; {t1} -> x1, Z6
  - Z6: {} -> x0, Z5; {t2} -> x1, Z7
  - Z7: {t1} -> x0, Z6; {t1,t2} -> x1, Z8
  - Z8: {t2} -> x0, Z7; {} -> x1, Z5
- Legal sample: st<=next, x_rec/x_ok and y_rec/y_ok<=decoded values. y_ok=1 only in Z2; x_ok=0 for the Z2 y1 entry.
- Illegal sample:
  - err<=1 for one cycle; err_cnt increments, saturating at 2^CNT_W-1.
  - st<=0, lock<=0, x_ok<=0, y_ok<=0.
- Re-lock: while lock=0, an internal run counter counts consecutive legal samples; lock<=1 on the LOCK_LEN-th. An illegal sample clears the counter.
- Latency: outputs are registered and valid the cycle after the sample edge. st then equals the automaton's own next-state register.
- Z0 reaches only {Z0,Z3,Z4}. ld seeds the other clusters.

Optional Feature:
- Macro: FSM_OBS_XCHK_EN.
- With the macro defined:
  - extra inputs x_ref and y_ref, the true automaton inputs, sampled with smp;
  - extra output mis, registered: 1 when (x_ok & x_rec!=x_ref) | (y_ok & y_rec!=y_ref);
  - mis is not counted in err_cnt.
- Without the macro: none of these ports or the logic exist.

Decomposition:
- Package fsm_obs_pkg:
  - state constants Z0..Z8 (4-bit) and NSTATE=9;
  - output-vector bit positions (T1=0, T2=1, T3=2, T4=3, T9=4);
  - decode-result struct {legal, x, x_ok, y, y_ok, nxt}.
- Sub-module fsm_obs_dec: purely combinational table lookup of (st, tvec) -> decode-result. The top level holds registers, lock/run counter, err_cnt.

Test Plan:
- res=1 then smp=1 with tvec {t2},{t4},{} -> st 4,3,0; x_rec 1,1,1; x_ok=1; err=0; lock=1.
- From Z0, smp with {t9} -> err pulse, err_cnt=1, st=0, lock=0. Then 4 × {} -> lock=1 after the 4th sample; a 5th illegal sample before that restarts the count.
- ld=1, ld_st=5, then {t1,t2},{t2},{t1},{} -> st 8,7,6,5; x_rec 0,0,0,0.
- ld_st=2, then {t1,t2,t3,t4} -> st=7, y_rec=1, y_ok=1, x_ok=0. Reload 2, then {} -> st=1, x_rec=1, y_rec=0.
- ld_st=12 -> err=1, st unchanged. 256 illegal samples with CNT_W=8 -> err_cnt holds at 255.
- res asserted mid-sequence at st=6 with ld=1 -> st=0, err_cnt=0 next cycle. With FSM_OBS_XCHK_EN, x_ref inverted -> mis=1.
